// File: rtl/sd_block_arbiter.sv
// Two-client arbiter for the single hps_io SD block channel: captures one request per
// client, grants round-robin and sequences one block transfer with an ack timeout.
module sd_block_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd12_000_000,
  parameter int          LBA_W   = 32
) (
  input  logic             CLK_VIDEO,
  input  logic             reset,
  input  logic [LBA_W-1:0] i_req0_lba,
  input  logic             i_req0_rd,
  input  logic             i_req0_wr,
  output logic             o_req0_busy,
  output logic             o_req0_done,
  output logic             o_req0_err,
  input  logic [LBA_W-1:0] i_req1_lba,
  input  logic             i_req1_rd,
  input  logic             i_req1_wr,
  output logic             o_req1_busy,
  output logic             o_req1_done,
  output logic             o_req1_err,
  output logic [LBA_W-1:0] o_sd_lba,
  output logic             o_sd_rd,
  output logic             o_sd_wr,
  input  logic             i_sd_ack,
  output logic             o_owner,
  output logic             o_active,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_XFER     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic             r_req0_rd_q, r_req0_wr_q, r_req1_rd_q, r_req1_wr_q;
  logic [1:0]       r_pend, r_dir;
  logic [LBA_W-1:0] r_lba0, r_lba1, r_sd_lba;
  logic             r_rr, r_owner, r_err, r_ack_q, r_sd_rd, r_sd_wr;
  logic [23:0]      r_cnt;

  logic w_rise0_rd, w_rise1_rd, w_cap0, w_cap1, w_grant, w_tmo, w_done0, w_done1;

  // Client protocol: a rising edge on rd or wr is a request and is accepted only while
  // busy is low; busy then stays high until the single-cycle done pulse of that request.
  assign w_rise0_rd = i_req0_rd & ~r_req0_rd_q;
  assign w_rise1_rd = i_req1_rd & ~r_req1_rd_q;
  assign w_cap0     = (w_rise0_rd | (i_req0_wr & ~r_req0_wr_q)) & ~o_req0_busy;
  assign w_cap1     = (w_rise1_rd | (i_req1_wr & ~r_req1_wr_q)) & ~o_req1_busy;
  assign w_grant    = (r_pend == 2'b11) ? ~r_rr : r_pend[1];
  assign w_tmo      = (r_cnt == TIMEOUT - 24'd1);

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (|r_pend) w_next = S_ISSUE;
      S_ISSUE:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: if (i_sd_ack) w_next = S_XFER;
                  else if (w_tmo) w_next = S_DONE;
      S_XFER:     if (r_ack_q && !i_sd_ack) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_done0     = (r_state == S_DONE) && !r_owner;
    w_done1     = (r_state == S_DONE) && r_owner;
    o_req0_done = w_done0;
    o_req1_done = w_done1;
    o_req0_err  = w_done0 & r_err;
    o_req1_err  = w_done1 & r_err;
    o_req0_busy = r_pend[0] & ~w_done0;
    o_req1_busy = r_pend[1] & ~w_done1;
    o_active    = (r_state != S_IDLE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      r_req0_rd_q <= 1'b0;
      r_req0_wr_q <= 1'b0;
      r_req1_rd_q <= 1'b0;
      r_req1_wr_q <= 1'b0;
      r_pend      <= '0;
      r_dir       <= '0;
      r_lba0      <= '0;
      r_lba1      <= '0;
      r_sd_lba    <= '0;
      r_sd_rd     <= 1'b0;
      r_sd_wr     <= 1'b0;
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_err       <= 1'b0;
      r_ack_q     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_req0_rd_q <= i_req0_rd;
      r_req0_wr_q <= i_req0_wr;
      r_req1_rd_q <= i_req1_rd;
      r_req1_wr_q <= i_req1_wr;
      r_ack_q     <= i_sd_ack;
      // A new capture in the DONE cycle wins over clearing the finished request.
      if (w_cap0) begin
        r_pend[0] <= 1'b1;
        r_lba0    <= i_req0_lba;
        r_dir[0]  <= ~w_rise0_rd;
      end else if (w_done0) begin
        r_pend[0] <= 1'b0;
      end
      if (w_cap1) begin
        r_pend[1] <= 1'b1;
        r_lba1    <= i_req1_lba;
        r_dir[1]  <= ~w_rise1_rd;
      end else if (w_done1) begin
        r_pend[1] <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (|r_pend) begin
          r_owner <= w_grant;
          r_err   <= 1'b0;
        end
        S_ISSUE: begin
          r_sd_lba <= r_owner ? r_lba1 : r_lba0;
          r_sd_rd  <= ~r_dir[r_owner];
          r_sd_wr  <= r_dir[r_owner];
          r_cnt    <= '0;
        end
        S_WAIT_ACK: begin
          if (i_sd_ack) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
          end else if (w_tmo) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_DONE:  r_rr <= r_owner;
        default: ;
      endcase
    end
  end

  assign o_sd_lba = r_sd_lba;
  assign o_sd_rd  = r_sd_rd;
  assign o_sd_wr  = r_sd_wr;
  assign o_owner  = r_owner;

endmodule
